logic_result_serializer: RTL

Sequential front-end that feeds operand pairs to the 8-bit combinational `AndOrNot` logic unit and streams its six results out one per beat. It accepts `(A, B)` over a valid/ready handshake and registers them. It captures all six results in one cycle, then emits them in ascending op order with backpressure. It is the consuming end of the logic unit's result bus, used between the operand source and the ALU result path.

---
 rtl/logic_unit_pkg.sv | 22 ++
 rtl/AndOrNot.sv | 22 ++
 rtl/logic_result_serializer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the 8-bit logic unit and its result serializer.
package logic_unit_pkg;

  localparam int unsigned NUM_OPS = 6;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned SEL_W   = OP_W + 1;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    EMIT
  } state_t;

endpackage

// File: rtl/AndOrNot.sv
// Combinational 8-bit logic unit: all six bitwise results of A and B.
module AndOrNot
  import logic_unit_pkg::*;
(
  output logic [DATA_W-1:0] And,
  output logic [DATA_W-1:0] Or,
  output logic [DATA_W-1:0] Xor,
  output logic [DATA_W-1:0] Nand,
  output logic [DATA_W-1:0] Nor,
  output logic [DATA_W-1:0] Xnor,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B
);

  assign And  = A & B;
  assign Or   = A | B;
  assign Xor  = A ^ B;
  assign Nand = ~(A & B);
  assign Nor  = ~(A | B);
  assign Xnor = ~(A ^ B);

endmodule

// File: rtl/logic_result_serializer.sv
// Accepts an operand pair, captures all logic-unit results at once, then
// streams the mask-enabled results out one beat at a time with backpressure.
module logic_result_serializer
  import logic_unit_pkg::*;
#(
  parameter logic [NUM_OPS-1:0] OP_MASK = 6'b111111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OP_W-1:0]   out_op,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  state_t                           state;
  logic [DATA_W-1:0]                op_a;
  logic [DATA_W-1:0]                op_b;
  logic [NUM_OPS-1:0][DATA_W-1:0]   res;
  logic [NUM_OPS-1:0][DATA_W-1:0]   lu;
  logic [DATA_W-1:0]                r_and, r_or, r_xor, r_nand, r_nor, r_xnor;
  logic [SEL_W-1:0]                 first_sel;
  logic [SEL_W-1:0]                 adv_sel;
  logic                             first_more;
  logic                             adv_more;

  // Lowest enabled op at or above 'from'; MSB flags that one exists.
  function automatic logic [SEL_W-1:0] next_op(input logic [SEL_W-1:0] from);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = int'(NUM_OPS) - 1; i >= 0; i--) begin
      if (OP_MASK[i] && (SEL_W'(i) >= from)) r = {1'b1, OP_W'(i)};
    end
    return r;
  endfunction

  function automatic logic any_from(input logic [SEL_W-1:0] from);
    logic r;
    r = 1'b0;
    for (int i = 0; i < int'(NUM_OPS); i++) begin
      if (OP_MASK[i] && (SEL_W'(i) >= from)) r = 1'b1;
    end
    return r;
  endfunction

  AndOrNot u_logic_unit (
    .And  (r_and),
    .Or   (r_or),
    .Xor  (r_xor),
    .Nand (r_nand),
    .Nor  (r_nor),
    .Xnor (r_xnor),
    .A    (op_a),
    .B    (op_b)
  );

  assign lu = {r_xnor, r_nor, r_nand, r_xor, r_or, r_and};

  assign first_sel  = next_op('0);
  assign first_more = any_from(SEL_W'(first_sel[OP_W-1:0]) + SEL_W'(1));
  assign adv_sel    = next_op(SEL_W'(out_op) + SEL_W'(1));
  assign adv_more   = any_from(SEL_W'(adv_sel[OP_W-1:0]) + SEL_W'(1));

  // out_op doubles as the emit index while in EMIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_op    <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      res       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a     <= in_a;
            op_b     <= in_b;
            in_ready <= 1'b0;
            state    <= CAPTURE;
          end
        end
        CAPTURE: begin
          res <= lu;
          if (first_sel[OP_W]) begin
            out_valid <= 1'b1;
            out_op    <= first_sel[OP_W-1:0];
            out_data  <= lu[first_sel[OP_W-1:0]];
            out_last  <= !first_more;
            state     <= EMIT;
          end else begin
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (out_last || !adv_sel[OP_W]) begin
              out_valid <= 1'b0;
              out_op    <= '0;
              out_data  <= '0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              state     <= IDLE;
            end else begin
              out_op   <= adv_sel[OP_W-1:0];
              out_data <= res[adv_sel[OP_W-1:0]];
              out_last <= !adv_more;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
